reg_write_arbiter: RTL and testbench
====================================

REG_WRITE_ARBITER -- requirements
Module: reg_write_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: width of the shared data register.
REQ-002 Parameter CNT_W, default 8: width of the write counter.
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 Reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 req0  input  1  requester 0 write request; held high until gnt0 is seen.
REQ-006 D0  input  WIDTH  requester 0 write data; stable while req0 is high.
REQ-007 req1  input  1  requester 1 write request; same rules as req0.
REQ-008 D1  input  WIDTH  requester 1 write data.
REQ-009 gnt0  output  1  one-cycle grant to requester 0, registered.
REQ-010 gnt1  output  1  one-cycle grant to requester 1, registered.
REQ-011 Q  output  WIDTH  shared register contents.
REQ-012 busy  output  1  high while the FSM is in any state other than IDLE.
REQ-013 wr_count  output  CNT_W  number of completed writes, saturating.

Function
REQ-014 The FSM SHALL have three states: IDLE, WR0 and WR1.
REQ-015 In IDLE, at a rising edge with exactly one req high, the FSM SHALL move to the matching WRx state.
REQ-016 In IDLE, at a rising edge with both req high, the FSM SHALL move to the WRx state of the requester that did not win last; the last-winner pointer resets to 1, so requester 0 wins first.
REQ-017 In IDLE with no req high, the FSM SHALL stay in IDLE.
REQ-018 gntx SHALL be high exactly during the cycle the FSM is in WRx; gnt0 and gnt1 are never high together.
REQ-019 At the rising edge that leaves WRx, the block SHALL load Q with Dx, set last-winner to x, and return to IDLE.
REQ-020 Q SHALL show the new data in the cycle after gntx; request-to-Q latency is 2 clocks.
REQ-021 Minimum spacing between grants SHALL be 2 clocks (WRx, then IDLE).
REQ-022 A requester SHALL deassert req in the cycle after its gnt; a req still high in IDLE counts as a new request.
REQ-023 With both requesters held high continuously, grants SHALL alternate 0,1,0,1,...
REQ-024 A req that drops before its grant SHALL NOT change arbitration already committed; the write in WRx still occurs with the current Dx.
REQ-025 Q SHALL hold its value in every cycle that is not a WRx exit edge.
REQ-026 wr_count SHALL increment by 1 on each WRx exit edge and saturate at 2^CNT_W-1 (no wrap).
REQ-027 busy SHALL equal (state != IDLE).

Reset
REQ-028 While Reset=0, asynchronously: state=IDLE, gnt0=gnt1=0, busy=0, Q=0, wr_count=0, last-winner=1.
REQ-029 Reset asserted during WRx SHALL abort that write: Q keeps its reset value 0 and wr_count does not increment.
REQ-030 After Reset is released, the first rising edge SHALL be able to accept a request.

Structure
REQ-031 A shared package SHALL hold the state encoding (IDLE=2'd0, WR0=2'd1, WR1=2'd2) and the default WIDTH and CNT_W values.
REQ-032 Q SHALL be implemented with one sub-module, dff_reg: a WIDTH-wide D register with asynchronous active-low reset and a load enable; the arbiter drives its enable and its data mux.

Verification
REQ-033 Reset=0 for 10 ns, then released; no req -> Q=0, wr_count=0, busy=0, both gnt low for 5 cycles.
REQ-034 req0=1, D0=8'hA5 for one request -> gnt0 high for one cycle at edge+1; Q=8'hA5 at edge+2; wr_count=1.
REQ-035 req0 and req1 held high with D0=8'h11 and D1=8'h22 for 8 cycles -> grant sequence 0,1,0,1; Q goes 11,22,11,22; wr_count=4.
REQ-036 Reset pulsed low while in WR1 with D1=8'hFF -> Q=0, wr_count=0, gnt1 drops immediately, state is IDLE.
REQ-037 CNT_W=2 with 5 back-to-back writes -> wr_count stops at 3.
REQ-038 req1 only, D1=8'h3C, then req0 one cycle later -> gnt1 first, then gnt0 two cycles later; final Q equals D0.

Source files
------------

// File: rtl/reg_write_arbiter_pkg.sv
// rtl/reg_write_arbiter_pkg.sv - shared state encoding and default widths for the write arbiter
package reg_write_arbiter_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR0  = 2'd1,
        WR1  = 2'd2
    } state_e;

endpackage

// File: rtl/reg_write_arbiter_dff_reg.sv
// rtl/reg_write_arbiter_dff_reg.sv - load-enabled data register with async active-low reset
module dff_reg
    import reg_write_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else if (en_i) begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - two-requester round-robin writer to a shared register
module reg_write_arbiter
    import reg_write_arbiter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             req0,
    input  logic [WIDTH-1:0] D0,
    input  logic             req1,
    input  logic [WIDTH-1:0] D1,
    output logic             gnt0,
    output logic             gnt1,
    output logic [WIDTH-1:0] Q,
    output logic             busy,
    output logic [CNT_W-1:0] wr_count
);

    state_e           state_q, state_d;
    logic             last_q, last_d;
    logic             gnt0_q, gnt1_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_en;
    logic [WIDTH-1:0] load_data;

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        load_en   = 1'b0;
        load_data = D0;
        case (state_q)
            IDLE: begin
                // On contention the requester that did not win last time goes first.
                if (req0 && req1) begin
                    state_d = last_q ? WR0 : WR1;
                end else if (req0) begin
                    state_d = WR0;
                end else if (req1) begin
                    state_d = WR1;
                end
            end
            WR0: begin
                state_d   = IDLE;
                load_en   = 1'b1;
                load_data = D0;
                last_d    = 1'b0;
            end
            WR1: begin
                state_d   = IDLE;
                load_en   = 1'b1;
                load_data = D1;
                last_d    = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (load_en && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            gnt0_q  <= (state_d == WR0);
            gnt1_q  <= (state_d == WR1);
            cnt_q   <= cnt_d;
        end
    end

    dff_reg #(
        .WIDTH(WIDTH)
    ) u_q_reg (
        .clk   (clk),
        .rst_n (Reset),
        .en_i  (load_en),
        .d_i   (load_data),
        .q_o   (Q)
    );

    assign gnt0     = gnt0_q;
    assign gnt1     = gnt1_q;
    assign busy     = (state_q != IDLE);
    assign wr_count = cnt_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - scoreboard bench for reg_write_arbiter with a saturating-counter twin
module tb_reg_write_arbiter;

    logic       clk;
    logic       Reset;
    logic       req0, req1;
    logic [7:0] D0, D1;
    logic       gnt0, gnt1, busy;
    logic [7:0] Q;
    logic [7:0] wr_count;
    logic       gnt0_s, gnt1_s, busy_s;
    logic [7:0] Q_s;
    logic [1:0] wr_count_s;

    reg_write_arbiter #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .Reset(Reset), .req0(req0), .D0(D0), .req1(req1), .D1(D1),
        .gnt0(gnt0), .gnt1(gnt1), .Q(Q), .busy(busy), .wr_count(wr_count)
    );

    reg_write_arbiter #(.WIDTH(8), .CNT_W(2)) dut_small (
        .clk(clk), .Reset(Reset), .req0(req0), .D0(D0), .req1(req1), .D1(D1),
        .gnt0(gnt0_s), .gnt1(gnt1_s), .Q(Q_s), .busy(busy_s), .wr_count(wr_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit         w;
        logic [7:0] d;
        logic [7:0] c8;
        logic [1:0] c2;
    } exp_t;

    exp_t q_exp[$];
    exp_t pend;
    bit   pend_v = 1'b0;
    logic [7:0] exp_q = 8'h00;
    logic [7:0] exp_c8 = 8'h00;
    logic [1:0] exp_c2 = 2'h0;
    bit   hist_w[$];
    int   hist_c[$];
    int   cyc = 0;

    // Reference model: each write is a transaction; arbitration chooses the requester that lost last time.
    bit m_busy = 1'b0;
    bit m_last = 1'b1;
    bit m_pend = 1'b0;
    int m_c8 = 0;
    int m_c2 = 0;

    always @(posedge clk) begin
        bit   w;
        exp_t e;
        if (!Reset) begin
            m_busy = 1'b0;
            m_last = 1'b1;
            m_c8   = 0;
            m_c2   = 0;
            q_exp.delete();
        end else if (m_busy) begin
            m_busy = 1'b0;
            m_last = m_pend;
        end else if (req0 || req1) begin
            w = (req0 && req1) ? !m_last : req1;
            m_pend = w;
            m_busy = 1'b1;
            if (m_c8 < 255) m_c8++;
            if (m_c2 < 3) m_c2++;
            e.w  = w;
            e.d  = w ? D1 : D0;
            e.c8 = m_c8[7:0];
            e.c2 = m_c2[1:0];
            q_exp.push_back(e);
        end
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        cyc++;
        if (Reset) begin
            if (pend_v) begin
                exp_q  = pend.d;
                exp_c8 = pend.c8;
                exp_c2 = pend.c2;
                pend_v = 1'b0;
            end
            check("q", Q, exp_q);
            check("q_small", Q_s, exp_q);
            check("wr_count", wr_count, exp_c8);
            check("wr_count_small", wr_count_s, exp_c2);
            if (gnt0 || gnt1) begin
                if (q_exp.size() == 0) begin
                    check("unexpected_grant", {gnt1, gnt0}, 2'b00);
                end else begin
                    e = q_exp.pop_front();
                    check("grant", {gnt1, gnt0}, e.w ? 2'b10 : 2'b01);
                    check("grant_small", {gnt1_s, gnt0_s}, e.w ? 2'b10 : 2'b01);
                    pend   = e;
                    pend_v = 1'b1;
                    hist_w.push_back(e.w);
                    hist_c.push_back(cyc);
                end
            end else if (q_exp.size() != 0) begin
                check("missing_grant", {gnt1, gnt0}, q_exp[0].w ? 2'b10 : 2'b01);
                void'(q_exp.pop_front());
            end
            check("busy", busy, pend_v);
            check("busy_small", busy_s, pend_v);
        end
    end

    bit drop_mode = 1'b1;

    task automatic step();
        @(negedge clk);
        if (drop_mode) begin
            if (gnt0) req0 = 1'b0;
            if (gnt1) req1 = 1'b0;
        end
    endtask

    task automatic pulse_reset();
        #1;
        Reset = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        m_busy = 1'b0;
        m_last = 1'b1;
        m_c8   = 0;
        m_c2   = 0;
        q_exp.delete();
        pend_v = 1'b0;
        exp_q  = 8'h00;
        exp_c8 = 8'h00;
        exp_c2 = 2'h0;
        hist_w.delete();
        hist_c.delete();
        #1;
        check("rst_gnt", {gnt1, gnt0, gnt1_s, gnt0_s}, 4'h0);
        check("rst_q", Q, 8'h00);
        check("rst_busy", {busy, busy_s}, 2'b00);
        check("rst_count", wr_count, 8'h00);
        check("rst_count_small", wr_count_s, 2'h0);
        #1;
        Reset = 1'b1;
    endtask

    initial begin
        Reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0;
        D0 = 8'h00; D1 = 8'h00;
        #8;
        check("init_q", Q, 8'h00);
        check("init_gnt", {gnt1, gnt0}, 2'b00);
        check("init_busy", busy, 1'b0);
        check("init_count", wr_count, 8'h00);
        #2;
        Reset = 1'b1;

        repeat (5) begin
            step();
            check("idle_busy", busy, 1'b0);
            check("idle_gnt", {gnt1, gnt0}, 2'b00);
            check("idle_q", Q, 8'h00);
        end

        // Single request from requester 0.
        drop_mode = 1'b1;
        req0 = 1'b1; D0 = 8'hA5;
        step();
        check("single_gnt0", gnt0, 1'b1);
        step();
        check("single_gnt0_low", gnt0, 1'b0);
        check("single_q", Q, 8'hA5);
        check("single_count", wr_count, 8'd1);
        step();

        // Both held: alternation and counter saturation on the narrow twin.
        pulse_reset();
        drop_mode = 1'b0;
        req0 = 1'b1; D0 = 8'h11;
        req1 = 1'b1; D1 = 8'h22;
        repeat (10) step();
        req0 = 1'b0; req1 = 1'b0;
        step();
        step();
        check("alt_count", wr_count, 8'd5);
        check("alt_count_sat", wr_count_s, 2'd3);
        check("alt_q", Q, 8'h11);
        check("alt_len", hist_w.size(), 5);
        for (int i = 0; i < 5 && i < hist_w.size(); i++) begin
            check("alt_order", hist_w[i], i % 2);
        end

        // Reset in the middle of a WR1 write.
        drop_mode = 1'b1;
        pulse_reset();
        req1 = 1'b1; D1 = 8'hFF;
        step();
        check("abort_gnt1", gnt1, 1'b1);
        pulse_reset();
        step();
        step();
        check("abort_q", Q, 8'h00);
        check("abort_count", wr_count, 8'h00);

        // req1 first, req0 one cycle later.
        pulse_reset();
        req1 = 1'b1; D1 = 8'h3C;
        step();
        req0 = 1'b1; D0 = 8'h5A;
        repeat (6) step();
        check("stag_q", Q, 8'h5A);
        check("stag_len", hist_w.size(), 2);
        if (hist_w.size() == 2) begin
            check("stag_first", hist_w[0], 1'b1);
            check("stag_second", hist_w[1], 1'b0);
            check("stag_spacing", hist_c[1] - hist_c[0], 2);
        end

        // Randomized traffic; data only changes while its request is low.
        pulse_reset();
        drop_mode = 1'b1;
        repeat (400) begin
            step();
            if (!req0 && !gnt0 && ($urandom_range(2) == 0)) begin
                D0 = 8'($urandom);
                req0 = 1'b1;
            end
            if (!req1 && !gnt1 && ($urandom_range(2) == 0)) begin
                D1 = 8'($urandom);
                req1 = 1'b1;
            end
        end
        req0 = 1'b0; req1 = 1'b0;
        repeat (4) step();
        check("drain", q_exp.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
